// File: rtl/sram.sv
// L1 data-cache data store: DEPTH entries of WIDTH bits, combinational read,
// synchronous per-word-masked write, asynchronous active-low clear of the whole array.
module sram #(
  parameter  int WORDSIZE = 64,
  parameter  int LOGWIDTH = 9,
  parameter  int LOGDEPTH = 9,
  localparam int WIDTH    = 2 ** LOGWIDTH,
  localparam int WORDS    = WIDTH / WORDSIZE,
  localparam int DEPTH    = 2 ** LOGDEPTH
) (
  input  logic                clk,
  input  logic [LOGDEPTH-1:0] readAddr,
  output logic [WIDTH-1:0]    readData,
  input  logic [LOGDEPTH-1:0] writeAddr,
  input  logic [WIDTH-1:0]    writeData,
  input  logic [WORDS-1:0]    writeEnable,
  input  logic                reset
);

  if (WORDSIZE <= 0 || (WIDTH % WORDSIZE) != 0) begin : g_bad_geometry
    $fatal(1, "sram: entry width %0d is not a multiple of WORDSIZE %0d", WIDTH, WORDSIZE);
  end

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [WIDTH-1:0]            entry_d;

  // Merge the enabled words of writeData over the current entry contents, so
  // disabled lanes (even if X) never reach the array.
  always_comb begin
    entry_d = mem_q[writeAddr];
    for (int w = 0; w < WORDS; w++) begin
      if (writeEnable[w]) begin
        entry_d[w*WORDSIZE +: WORDSIZE] = writeData[w*WORDSIZE +: WORDSIZE];
      end
    end
  end

  // NOTE: the whole array is cleared on reset on purpose -- the cache relies on
  // never-written entries reading as zero, so this cannot be a plain macro.
  // NOTE: non-blocking assignment keeps the read of mem_q in this cycle seeing
  // the old contents until the edge commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else if (|writeEnable) begin
      mem_q[writeAddr] <= entry_d;
    end
  end

  // No write-through bypass: a same-address read shows new data only after the edge.
  assign readData = mem_q[readAddr];

endmodule

// File: tb/tb_sram.sv
// Self-checking bench for sram: directed scenarios plus randomized traffic
// compared against a whole-entry mask-merge reference model.
module tb_sram;
  localparam int WORDSIZE = 64;
  localparam int LOGWIDTH = 9;
  localparam int LOGDEPTH = 9;
  localparam int WIDTH    = 2 ** LOGWIDTH;
  localparam int WORDS    = WIDTH / WORDSIZE;
  localparam int DEPTH    = 2 ** LOGDEPTH;

  logic                clk = 1'b0;
  logic                reset;
  logic [LOGDEPTH-1:0] readAddr;
  logic [WIDTH-1:0]    readData;
  logic [LOGDEPTH-1:0] writeAddr;
  logic [WIDTH-1:0]    writeData;
  logic [WORDS-1:0]    writeEnable;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] full_pattern;

  always #5 clk = ~clk;

  sram #(.WORDSIZE(WORDSIZE), .LOGWIDTH(LOGWIDTH), .LOGDEPTH(LOGDEPTH)) dut (
    .clk        (clk),
    .readAddr   (readAddr),
    .readData   (readData),
    .writeAddr  (writeAddr),
    .writeData  (writeData),
    .writeEnable(writeEnable),
    .reset      (reset)
  );

  function automatic logic [WIDTH-1:0] lane_mask(input logic [WORDS-1:0] en);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int w = 0; w < WORDS; w++) m[w*WORDSIZE +: WORDSIZE] = {WORDSIZE{en[w]}};
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] rand_entry();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic model_write(input int addr, input logic [WIDTH-1:0] data,
                             input logic [WORDS-1:0] en);
    logic [WIDTH-1:0] m;
    m = lane_mask(en);
    model[addr] = (model[addr] & ~m) | (data & m);
  endtask

  // Presents a write on the falling edge, commits it on the rising edge, then
  // leaves the bench 1 time unit after the rising edge with writes disabled.
  task automatic clock_write(input int addr, input logic [WIDTH-1:0] data,
                             input logic [WORDS-1:0] en);
    @(negedge clk);
    writeAddr   = LOGDEPTH'(addr);
    writeData   = data;
    writeEnable = en;
    @(posedge clk);
    if (reset) model_write(addr, data, en);
    #1;
    writeEnable = '0;
  endtask

  task automatic test_reset();
    int addrs [4] = '{0, 1, 255, 511};
    reset = 1'b0;
    writeEnable = '0;
    writeAddr = '0;
    writeData = '0;
    readAddr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      readAddr = LOGDEPTH'(addrs[i]);
      #1;
      checks++;
      if (readData !== '0) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h expected 0", addrs[i], readData);
      end
    end
  endtask

  task automatic test_full_write();
    for (int w = 0; w < WORDS; w++)
      full_pattern[w*WORDSIZE +: WORDSIZE] = {16{4'(w + 1)}};
    @(negedge clk);
    readAddr = 9'd5;
    clock_write(5, full_pattern, '1);
    checks++;
    if (readData !== full_pattern) begin
      errors++;
      $display("FAIL full_write: got %h expected %h", readData, full_pattern);
    end
  endtask

  task automatic test_partial_write();
    logic [WIDTH-1:0] exp;
    exp = full_pattern;
    exp[0*WORDSIZE +: WORDSIZE] = '1;
    exp[2*WORDSIZE +: WORDSIZE] = '1;
    clock_write(5, '1, 8'b0000_0101);
    checks++;
    if (readData !== exp || readData !== model[5]) begin
      errors++;
      $display("FAIL partial_write: got %h expected %h", readData, exp);
    end
  endtask

  task automatic test_read_during_write();
    logic [WIDTH-1:0] pat, xdata, exp;
    pat = {(WIDTH/8){8'hA5}};
    @(negedge clk);
    readAddr = 9'd10;
    writeAddr = 9'd10;
    writeData = pat;
    writeEnable = '1;
    #1;
    checks++;
    if (readData !== '0) begin
      errors++;
      $display("FAIL rdw_before_edge: got %h expected 0", readData);
    end
    @(posedge clk);
    model_write(10, pat, '1);
    #1;
    checks++;
    if (readData !== pat) begin
      errors++;
      $display("FAIL rdw_after_edge: got %h expected %h", readData, pat);
    end
    writeEnable = '0;
    @(negedge clk);
    writeData = {(WIDTH/8){8'h5A}};
    @(posedge clk);
    #1;
    checks++;
    if (readData !== pat) begin
      errors++;
      $display("FAIL rdw_enable_zero: got %h expected %h", readData, pat);
    end
    // X on disabled lanes must never reach the array.
    xdata = 'x;
    xdata[0 +: WORDSIZE] = 64'h0123_4567_89AB_CDEF;
    exp = pat;
    exp[0 +: WORDSIZE] = 64'h0123_4567_89AB_CDEF;
    clock_write(10, xdata, 8'h01);
    checks++;
    if (readData !== exp) begin
      errors++;
      $display("FAIL rdw_x_disabled_lanes: got %h expected %h", readData, exp);
    end
  endtask

  task automatic test_boundary();
    logic [WIDTH-1:0] pa, pb;
    pa = rand_entry();
    pb = rand_entry();
    @(negedge clk);
    readAddr = 9'd0;
    clock_write(0, pa, '1);
    checks++;
    if (readData !== pa) begin
      errors++;
      $display("FAIL boundary_entry0: got %h expected %h", readData, pa);
    end
    @(negedge clk);
    readAddr = 9'(DEPTH - 1);
    clock_write(DEPTH - 1, pb, '1);
    checks++;
    if (readData !== pb) begin
      errors++;
      $display("FAIL boundary_entry511: got %h expected %h", readData, pb);
    end
    @(negedge clk);
    readAddr = 9'd0;
    #1;
    checks++;
    if (readData !== pa) begin
      errors++;
      $display("FAIL boundary_no_alias0: got %h expected %h", readData, pa);
    end
    readAddr = 9'(DEPTH - 1);
    #1;
    checks++;
    if (readData !== pb) begin
      errors++;
      $display("FAIL boundary_no_alias511: got %h expected %h", readData, pb);
    end
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] d;
    d = rand_entry() | 1;
    clock_write(3, d, '1);
    @(negedge clk);
    readAddr = 9'd3;
    #1;
    checks++;
    if (readData !== d) begin
      errors++;
      $display("FAIL async_pre_reset: got %h expected %h", readData, d);
    end
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (readData !== '0) begin
      errors++;
      $display("FAIL async_clear_no_edge: got %h expected 0", readData);
    end
    writeAddr = 9'd3;
    writeData = rand_entry();
    writeEnable = '1;
    @(posedge clk);
    #1;
    checks++;
    if (readData !== '0) begin
      errors++;
      $display("FAIL async_write_in_reset: got %h expected 0", readData);
    end
    @(negedge clk);
    writeEnable = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (readData !== '0) begin
      errors++;
      $display("FAIL async_after_release: got %h expected 0", readData);
    end
  endtask

  task automatic test_random();
    int pool [5] = '{0, 1, 3, 10, DEPTH - 1};
    int wa, ra;
    logic [WIDTH-1:0] d;
    logic [WORDS-1:0] en;
    for (int n = 0; n < 300; n++) begin
      wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                       : pool[$urandom_range(0, 4)];
      ra = ($urandom_range(0, 1) == 0) ? wa : pool[$urandom_range(0, 4)];
      case ($urandom_range(0, 5))
        0:       en = '0;
        1:       en = '1;
        default: en = WORDS'($urandom);
      endcase
      d = rand_entry();
      if ($urandom_range(0, 2) == 0) begin
        for (int w = 0; w < WORDS; w++)
          if (!en[w]) d[w*WORDSIZE +: WORDSIZE] = 'x;
      end
      @(negedge clk);
      writeAddr = LOGDEPTH'(wa);
      readAddr = LOGDEPTH'(ra);
      writeData = d;
      writeEnable = en;
      #1;
      checks++;
      if (readData !== model[ra]) begin
        errors++;
        $display("FAIL random_pre[%0d] addr %0d: got %h expected %h", n, ra, readData, model[ra]);
      end
      @(posedge clk);
      model_write(wa, d, en);
      #1;
      checks++;
      if (readData !== model[ra]) begin
        errors++;
        $display("FAIL random_post[%0d] addr %0d: got %h expected %h", n, ra, readData, model[ra]);
      end
      writeEnable = '0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    test_reset();
    test_full_write();
    test_partial_write();
    test_read_during_write();
    test_boundary();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
